// File: rtl/wb_burst_pkg.sv
// Shared types and helpers for the Wishbone burst memory slave.
// Holds the FSM state encoding, the burst-length width and the last-beat test.
package wb_burst_pkg;

    localparam int BL_W = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_WAIT,
        ST_WR_ACK,
        ST_RD_ISSUE,
        ST_RD_WAIT,
        ST_RD_ACK
    } state_e;

    function automatic logic is_last_beat(input logic [BL_W-1:0] cnt);
        return cnt == BL_W'(1);
    endfunction

endpackage

// File: rtl/wb_burst_mem_slave.sv
// Extended-Wishbone burst slave on a 1-cycle-latency SRAM: write beat = 2 cycles, read beat = 3.
// Backpressure: a beat is only issued to the SRAM when cyc&stb&bry; dropping req before issue aborts.
module wb_burst_mem_slave
    import wb_burst_pkg::*;
#(
    parameter int AW = 9
) (
    input  logic            clk_i,
    input  logic            rst_n,
    input  logic [31:0]     wbd_dat_i,
    input  logic [31:0]     wbd_adr_i,
    input  logic [3:0]      wbd_sel_i,
    input  logic [BL_W-1:0] wbd_bl_i,
    input  logic            wbd_bry_i,
    input  logic            wbd_we_i,
    input  logic            wbd_cyc_i,
    input  logic            wbd_stb_i,
    output logic [31:0]     wbd_dat_o,
    output logic            wbd_ack_o,
    output logic            wbd_lack_o,
    output logic            wbd_err_o,
    output logic            mem_cs_o,
    output logic            mem_we_o,
    output logic [AW-1:0]   mem_addr_o,
    output logic [31:0]     mem_wdata_o,
    output logic [3:0]      mem_wmask_o,
    input  logic [31:0]     mem_rdata_i
);

    state_e          state_q, state_d;
    logic [AW-1:0]   adr_cnt_q, adr_cnt_d;
    logic [BL_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [31:0]     dat_q, dat_d;
    logic            ack_q, ack_d;
    logic            lack_q, lack_d;
    logic            err_q, err_d;
    logic            req;
    logic            last_beat;

    // Address bits outside the word index carry no meaning for this slave.
    logic unused_adr_bits;
    assign unused_adr_bits = ^{wbd_adr_i[31:AW+2], wbd_adr_i[1:0]};

    assign req       = wbd_cyc_i & wbd_stb_i;
    assign last_beat = is_last_beat(beat_cnt_q);

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            adr_cnt_q  <= '0;
            beat_cnt_q <= '0;
            dat_q      <= '0;
            ack_q      <= 1'b0;
            lack_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            adr_cnt_q  <= adr_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            dat_q      <= dat_d;
            ack_q      <= ack_d;
            lack_q     <= lack_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        adr_cnt_d   = adr_cnt_q;
        beat_cnt_d  = beat_cnt_q;
        dat_d       = dat_q;
        ack_d       = 1'b0;
        lack_d      = 1'b0;
        err_d       = 1'b0;
        mem_cs_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = adr_cnt_q;
        mem_wdata_o = wbd_dat_i;
        mem_wmask_o = wbd_sel_i;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    adr_cnt_d  = wbd_adr_i[AW+1:2];
                    beat_cnt_d = wbd_bl_i;
                    if (wbd_bl_i == '0) begin
                        // Zero-length burst: terminate with err+lack, never touch the SRAM.
                        err_d  = 1'b1;
                        lack_d = 1'b1;
                    end else if (wbd_we_i) begin
                        state_d = ST_WR_WAIT;
                    end else begin
                        state_d = ST_RD_ISSUE;
                    end
                end
            end
            ST_WR_WAIT: begin
                if (!req) begin
                    state_d = ST_IDLE;
                end else if (wbd_bry_i) begin
                    mem_cs_o = 1'b1;
                    mem_we_o = 1'b1;
                    ack_d    = 1'b1;
                    lack_d   = last_beat;
                    state_d  = ST_WR_ACK;
                end
            end
            ST_WR_ACK: begin
                adr_cnt_d  = adr_cnt_q + AW'(1);
                beat_cnt_d = beat_cnt_q - BL_W'(1);
                state_d    = last_beat ? ST_IDLE : ST_WR_WAIT;
            end
            ST_RD_ISSUE: begin
                if (!req) begin
                    state_d = ST_IDLE;
                end else if (wbd_bry_i) begin
                    mem_cs_o = 1'b1;
                    state_d  = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                // An issued read always completes, regardless of req.
                dat_d   = mem_rdata_i;
                ack_d   = 1'b1;
                lack_d  = last_beat;
                state_d = ST_RD_ACK;
            end
            ST_RD_ACK: begin
                adr_cnt_d  = adr_cnt_q + AW'(1);
                beat_cnt_d = beat_cnt_q - BL_W'(1);
                state_d    = last_beat ? ST_IDLE : ST_RD_ISSUE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign wbd_dat_o  = dat_q;
    assign wbd_ack_o  = ack_q;
    assign wbd_lack_o = lack_q;
    assign wbd_err_o  = err_q;

endmodule

// File: tb/tb_wb_burst_mem_slave.sv
// Directed bench for wb_burst_mem_slave: expected responses and SRAM accesses are
// queued with their cycle numbers and checked by monitors as the DUT produces them.
module tb_wb_burst_mem_slave;

    localparam int AW = 9;

    logic          clk_i = 1'b0;
    logic          rst_n;
    logic [31:0]   wbd_dat_i;
    logic [31:0]   wbd_adr_i;
    logic [3:0]    wbd_sel_i;
    logic [9:0]    wbd_bl_i;
    logic          wbd_bry_i;
    logic          wbd_we_i;
    logic          wbd_cyc_i;
    logic          wbd_stb_i;
    logic [31:0]   wbd_dat_o;
    logic          wbd_ack_o;
    logic          wbd_lack_o;
    logic          wbd_err_o;
    logic          mem_cs_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [31:0]   mem_wdata_o;
    logic [3:0]    mem_wmask_o;
    logic [31:0]   mem_rdata_i;

    wb_burst_mem_slave #(.AW(AW)) dut (
        .clk_i       (clk_i),
        .rst_n       (rst_n),
        .wbd_dat_i   (wbd_dat_i),
        .wbd_adr_i   (wbd_adr_i),
        .wbd_sel_i   (wbd_sel_i),
        .wbd_bl_i    (wbd_bl_i),
        .wbd_bry_i   (wbd_bry_i),
        .wbd_we_i    (wbd_we_i),
        .wbd_cyc_i   (wbd_cyc_i),
        .wbd_stb_i   (wbd_stb_i),
        .wbd_dat_o   (wbd_dat_o),
        .wbd_ack_o   (wbd_ack_o),
        .wbd_lack_o  (wbd_lack_o),
        .wbd_err_o   (wbd_err_o),
        .mem_cs_o    (mem_cs_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_wmask_o (mem_wmask_o),
        .mem_rdata_i (mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    int cycle_n = 0;
    always @(posedge clk_i) cycle_n <= cycle_n + 1;

    typedef struct {
        int          cyc;
        logic        ack;
        logic        lack;
        logic        err;
        logic        chk_dat;
        logic [31:0] dat;
    } rsp_t;

    typedef struct {
        int          cyc;
        logic        we;
        logic [8:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } acc_t;

    rsp_t        rsp_q[$];
    acc_t        acc_q[$];
    logic [31:0] mem [512];
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic exp_rsp(input int c, input logic ack, input logic lack, input logic err,
                           input logic chk, input logic [31:0] dat);
        rsp_t e;
        e.cyc = c; e.ack = ack; e.lack = lack; e.err = err; e.chk_dat = chk; e.dat = dat;
        rsp_q.push_back(e);
    endtask

    task automatic exp_acc(input int c, input logic we, input logic [8:0] addr,
                           input logic [31:0] wdata, input logic [3:0] wmask);
        acc_t e;
        e.cyc = c; e.we = we; e.addr = addr; e.wdata = wdata; e.wmask = wmask;
        acc_q.push_back(e);
    endtask

    task automatic begin_burst(output int c0);
        @(posedge clk_i);
        #1;
        c0 = cycle_n;
    endtask

    // Drives one burst for len cycles starting now (offset t = 0 is the IDLE request cycle).
    task automatic drive(input logic we, input logic [31:0] adr, input logic [9:0] bl,
                         input logic [3:0] sel, input logic [31:0] dbase, input int len,
                         input int st_lo, input int st_hi, input int rst_t);
        for (int t = 0; t < len; t++) begin
            if (t == rst_t) begin
                rst_n     = 1'b0;
                wbd_cyc_i = 1'b0;
                wbd_stb_i = 1'b0;
                wbd_bry_i = 1'b0;
                @(negedge clk_i);
                n_cmp++;
                if ({wbd_dat_o, wbd_ack_o, wbd_lack_o, wbd_err_o, mem_cs_o, mem_we_o} != '0) begin
                    n_bad++;
                    $display("FAIL rst_mid: dat=%h ack=%b lack=%b err=%b cs=%b we=%b, required all zero",
                             wbd_dat_o, wbd_ack_o, wbd_lack_o, wbd_err_o, mem_cs_o, mem_we_o);
                end
                @(posedge clk_i);
                #1;
                rst_n = 1'b1;
                return;
            end
            wbd_cyc_i = 1'b1;
            wbd_stb_i = 1'b1;
            wbd_we_i  = we;
            wbd_adr_i = adr;
            wbd_bl_i  = bl;
            wbd_sel_i = sel;
            wbd_bry_i = !(t >= st_lo && t < st_hi);
            wbd_dat_i = dbase + 32'((t > 0) ? (t - 1) / 2 : 0);
            @(posedge clk_i);
            #1;
        end
        wbd_cyc_i = 1'b0;
        wbd_stb_i = 1'b0;
        wbd_bry_i = 1'b0;
    endtask

    initial begin
        int c0;
        rst_n       = 1'b0;
        wbd_dat_i   = '0;
        wbd_adr_i   = '0;
        wbd_sel_i   = '0;
        wbd_bl_i    = '0;
        wbd_bry_i   = 1'b0;
        wbd_we_i    = 1'b0;
        wbd_cyc_i   = 1'b0;
        wbd_stb_i   = 1'b0;
        mem_rdata_i = '0;
        for (int i = 0; i < 512; i++) mem[i] = 32'h1000_0000 + 32'(i);

        fork
            // SRAM model: one-cycle read latency, byte-masked writes.
            forever begin
                @(posedge clk_i);
                if (mem_cs_o === 1'b1) begin
                    if (mem_we_o) begin
                        for (int b = 0; b < 4; b++)
                            if (mem_wmask_o[b]) mem[mem_addr_o][8*b +: 8] = mem_wdata_o[8*b +: 8];
                    end else begin
                        mem_rdata_i <= mem[mem_addr_o];
                    end
                end
            end
            // Monitor: every response pulse and every SRAM access must match the queue head.
            forever begin
                @(negedge clk_i);
                if (rst_n && (wbd_ack_o || wbd_lack_o || wbd_err_o)) begin
                    n_cmp++;
                    if (rsp_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL rsp_unexpected: cycle %0d ack=%b lack=%b err=%b dat=%h, required no response",
                                 cycle_n, wbd_ack_o, wbd_lack_o, wbd_err_o, wbd_dat_o);
                    end else begin
                        rsp_t e;
                        e = rsp_q.pop_front();
                        if (cycle_n != e.cyc || wbd_ack_o != e.ack || wbd_lack_o != e.lack ||
                            wbd_err_o != e.err || (e.chk_dat && wbd_dat_o != e.dat)) begin
                            n_bad++;
                            $display("FAIL rsp: cycle %0d ack=%b lack=%b err=%b dat=%h, required cycle %0d ack=%b lack=%b err=%b dat=%h",
                                     cycle_n, wbd_ack_o, wbd_lack_o, wbd_err_o, wbd_dat_o,
                                     e.cyc, e.ack, e.lack, e.err, e.dat);
                        end
                    end
                end
                if (rst_n && mem_cs_o === 1'b1) begin
                    n_cmp++;
                    if (acc_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL mem_unexpected: cycle %0d we=%b addr=%0d, required no access",
                                 cycle_n, mem_we_o, mem_addr_o);
                    end else begin
                        acc_t a;
                        a = acc_q.pop_front();
                        if (cycle_n != a.cyc || mem_we_o != a.we || mem_addr_o != a.addr ||
                            (a.we && (mem_wdata_o != a.wdata || mem_wmask_o != a.wmask))) begin
                            n_bad++;
                            $display("FAIL mem: cycle %0d we=%b addr=%0d wdata=%h mask=%h, required cycle %0d we=%b addr=%0d wdata=%h mask=%h",
                                     cycle_n, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
                                     a.cyc, a.we, a.addr, a.wdata, a.wmask);
                        end
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        n_cmp++;
        if ({wbd_dat_o, wbd_ack_o, wbd_lack_o, wbd_err_o, mem_cs_o, mem_we_o} != '0) begin
            n_bad++;
            $display("FAIL reset: dat=%h ack=%b lack=%b err=%b cs=%b we=%b, required all zero",
                     wbd_dat_o, wbd_ack_o, wbd_lack_o, wbd_err_o, mem_cs_o, mem_we_o);
        end
        @(posedge clk_i);
        #1;
        rst_n = 1'b1;

        // Single write to word 4, then read it back.
        begin_burst(c0);
        exp_acc(c0 + 1, 1'b1, 9'd4, 32'hA5A5_0001, 4'hF);
        exp_rsp(c0 + 2, 1'b1, 1'b1, 1'b0, 1'b0, '0);
        drive(1'b1, 32'h10, 10'd1, 4'hF, 32'hA5A5_0001, 3, -1, -1, -1);

        begin_burst(c0);
        exp_acc(c0 + 1, 1'b0, 9'd4, '0, '0);
        exp_rsp(c0 + 3, 1'b1, 1'b1, 1'b0, 1'b1, 32'hA5A5_0001);
        drive(1'b0, 32'h10, 10'd1, 4'h0, '0, 4, -1, -1, -1);

        // 4-beat masked write to words 8..11, then read them back.
        begin_burst(c0);
        for (int k = 0; k < 4; k++) begin
            exp_acc(c0 + 1 + 2*k, 1'b1, 9'(8 + k), 32'hCAFE_1230 + 32'(k), 4'h3);
            exp_rsp(c0 + 2 + 2*k, 1'b1, k == 3, 1'b0, 1'b0, '0);
        end
        drive(1'b1, 32'h20, 10'd4, 4'h3, 32'hCAFE_1230, 9, -1, -1, -1);

        begin_burst(c0);
        for (int k = 0; k < 4; k++) begin
            exp_acc(c0 + 1 + 3*k, 1'b0, 9'(8 + k), '0, '0);
            exp_rsp(c0 + 3 + 3*k, 1'b1, k == 3, 1'b0, 1'b1, 32'h1000_1230 + 32'(k));
        end
        drive(1'b0, 32'h20, 10'd4, 4'h0, '0, 13, -1, -1, -1);

        // Read burst wrapping 511 -> 0 -> 1; upper address bits set and ignored.
        begin_burst(c0);
        exp_acc(c0 + 1, 1'b0, 9'd511, '0, '0);
        exp_acc(c0 + 4, 1'b0, 9'd0, '0, '0);
        exp_acc(c0 + 7, 1'b0, 9'd1, '0, '0);
        exp_rsp(c0 + 3, 1'b1, 1'b0, 1'b0, 1'b1, 32'h1000_01FF);
        exp_rsp(c0 + 6, 1'b1, 1'b0, 1'b0, 1'b1, 32'h1000_0000);
        exp_rsp(c0 + 9, 1'b1, 1'b1, 1'b0, 1'b1, 32'h1000_0001);
        drive(1'b0, 32'hFFFF_F7FC, 10'd3, 4'h0, '0, 10, -1, -1, -1);

        // Read burst from word 20 with bry low for 5 cycles before the second beat.
        begin_burst(c0);
        exp_acc(c0 + 1, 1'b0, 9'd20, '0, '0);
        exp_acc(c0 + 9, 1'b0, 9'd21, '0, '0);
        exp_acc(c0 + 12, 1'b0, 9'd22, '0, '0);
        exp_rsp(c0 + 3, 1'b1, 1'b0, 1'b0, 1'b1, 32'h1000_0014);
        exp_rsp(c0 + 11, 1'b1, 1'b0, 1'b0, 1'b1, 32'h1000_0015);
        exp_rsp(c0 + 14, 1'b1, 1'b1, 1'b0, 1'b1, 32'h1000_0016);
        drive(1'b0, 32'h50, 10'd3, 4'h0, '0, 15, 4, 9, -1);

        // Zero-length burst: err and lack together, no SRAM access.
        begin_burst(c0);
        exp_rsp(c0 + 1, 1'b0, 1'b1, 1'b1, 1'b0, '0);
        drive(1'b1, 32'h0, 10'd0, 4'hF, 32'hDEAD_BEEF, 1, -1, -1, -1);

        // Strobe dropped after the first beat of a 4-beat write to word 16.
        begin_burst(c0);
        exp_acc(c0 + 1, 1'b1, 9'd16, 32'h5555_0000, 4'hF);
        exp_rsp(c0 + 2, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        drive(1'b1, 32'h40, 10'd4, 4'hF, 32'h5555_0000, 3, -1, -1, -1);

        begin_burst(c0);
        exp_acc(c0 + 1, 1'b0, 9'd16, '0, '0);
        exp_acc(c0 + 4, 1'b0, 9'd17, '0, '0);
        exp_rsp(c0 + 3, 1'b1, 1'b0, 1'b0, 1'b1, 32'h5555_0000);
        exp_rsp(c0 + 6, 1'b1, 1'b1, 1'b0, 1'b1, 32'h1000_0011);
        drive(1'b0, 32'h40, 10'd2, 4'h0, '0, 7, -1, -1, -1);

        // Reset pulsed during the second beat of a write burst to word 32.
        begin_burst(c0);
        exp_acc(c0 + 1, 1'b1, 9'd32, 32'h7777_0000, 4'hF);
        exp_rsp(c0 + 2, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        drive(1'b1, 32'h80, 10'd4, 4'hF, 32'h7777_0000, 9, -1, -1, 3);

        begin_burst(c0);
        exp_acc(c0 + 1, 1'b0, 9'd32, '0, '0);
        exp_acc(c0 + 4, 1'b0, 9'd33, '0, '0);
        exp_rsp(c0 + 3, 1'b1, 1'b0, 1'b0, 1'b1, 32'h7777_0000);
        exp_rsp(c0 + 6, 1'b1, 1'b1, 1'b0, 1'b1, 32'h1000_0021);
        drive(1'b0, 32'h80, 10'd2, 4'h0, '0, 7, -1, -1, -1);

        repeat (6) @(posedge clk_i);
        #1;
        while (rsp_q.size() != 0) begin
            rsp_t e;
            e = rsp_q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL rsp_missing: no response observed, required cycle %0d ack=%b lack=%b err=%b dat=%h",
                     e.cyc, e.ack, e.lack, e.err, e.dat);
        end
        while (acc_q.size() != 0) begin
            acc_t a;
            a = acc_q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL mem_missing: no access observed, required cycle %0d we=%b addr=%0d",
                     a.cyc, a.we, a.addr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_burst_mem_slave.md
# wb_burst_mem_slave

Wishbone burst responder that terminates the team's extended Wishbone interface (bl/bry/lack) on a single-port synchronous SRAM macro. It sits on the slave side of a staging stage in the interconnect, accepts single and burst transfers, and generates a per-beat ack plus a last-beat lack. One beat completes every 2 cycles for writes and every 3 for reads, matching the one-cycle gap the staging stage inserts between beats.

## Interface
- AW, 9, SRAM word-address width; memory depth is 2^AW 32-bit words
- clk_i  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- wbd_dat_i  in  32  write data
- wbd_adr_i  in  32  byte address; bits [AW+1:2] are used, all others ignored
- wbd_sel_i  in  4  byte enables for writes; ignored for reads
- wbd_bl_i  in  10  burst length in beats; 0 is illegal
- wbd_bry_i  in  1  master ready for the next beat (write data valid / read data can be taken)
- wbd_we_i  in  1  1 = write, 0 = read
- wbd_cyc_i, wbd_stb_i  in  1 each  cycle and strobe
- wbd_dat_o  out  32  read data (registered)
- wbd_ack_o  out  1  per-beat acknowledge (registered)
- wbd_lack_o  out  1  last-beat acknowledge (registered)
- wbd_err_o  out  1  error (registered)
- mem_cs_o  out  1  SRAM chip select, active-high
- mem_we_o  out  1  SRAM write enable
- mem_addr_o  out  AW  SRAM word address
- mem_wdata_o  out  32  SRAM write data
- mem_wmask_o  out  4  SRAM byte mask
- mem_rdata_i  in  32  SRAM read data, valid the cycle after a read access

## Operation
- Request condition is req = wbd_cyc_i & wbd_stb_i.
- States: IDLE, WR_WAIT, WR_ACK, RD_ISSUE, RD_WAIT, RD_ACK.
- IDLE on req:
  - latch adr_cnt = wbd_adr_i[AW+1:2], beat_cnt = wbd_bl_i, dir = wbd_we_i.
  - If bl == 0: next cycle pulse err_o = 1 and lack_o = 1 together (ack_o = 0), no memory access, then return to IDLE.
  - Otherwise go to WR_WAIT or RD_ISSUE.
- WR_WAIT:
  - On req & bry: mem_cs_o = 1, mem_we_o = 1, mem_addr_o = adr_cnt, mem_wdata_o = wbd_dat_i, mem_wmask_o = wbd_sel_i (all combinational). Go to WR_ACK.
  - On !req: abort to IDLE.
  - On req & !bry: stay.
- WR_ACK: ack_o = 1; lack_o = 1 if beat_cnt was 1. adr_cnt increments, beat_cnt decrements. Go to WR_WAIT, or to IDLE on the last beat.
- RD_ISSUE:
  - On req & bry: mem_cs_o = 1, mem_we_o = 0, mem_addr_o = adr_cnt. Go to RD_WAIT.
  - On !req: abort to IDLE.
  - On req & !bry: stay.
- RD_WAIT: capture mem_rdata_i into dat_o; set ack_o (and lack_o on the last beat) for the next cycle. Go to RD_ACK. A read that has already been issued always completes, even if req drops.
- RD_ACK: ack visible; counters update. Go to RD_ISSUE, or to IDLE on the last beat.
- adr_cnt is AW bits wide and wraps modulo 2^AW (last word + 1 → 0), with no error.
- beat_cnt is 10 bits; the last beat is the one where beat_cnt == 1.
- mem_cs_o = 0 in every state not listed above. mem_wdata_o and mem_wmask_o are don't-care when mem_cs_o = 0.

## Timing
- Reset values: dat_o = 0, ack_o = 0, lack_o = 0, err_o = 0, mem_cs_o = 0, mem_we_o = 0, state = IDLE, counters = 0.
- Reset asserted mid-burst returns the block to IDLE immediately; no ack is issued for an in-flight beat.
- Write: request sampled in cycle T0 (IDLE), first SRAM write in T1 if bry, ack in T2. Each further beat follows 2 cycles after the previous ack cycle when bry is held high.
- Read: request in T0, SRAM read in T1, data captured in T2, ack and dat_o valid in T3. Beat period is 3 cycles.
- ack_o, lack_o and err_o are single-cycle pulses.
- dat_o holds the last read data until the next read capture.
- lack_o is asserted only together with ack_o, except in the bl == 0 error case.
- A req still present in the IDLE cycle immediately after lack is treated as a new burst.

## Structure
- Package wb_burst_pkg holds:
  - the state enum;
  - the BL_W = 10 constant;
  - a helper for the last-beat compare.
- A single module with no sub-modules. The SRAM macro is instantiated by the parent.

## Test plan
- Single write: adr 0x10, bl = 1, sel 0xF, dat 0xA5A5_0001 → mem write at word 4 in T1; ack = lack = 1 in T2; a readback returns 0xA5A5_0001 with ack = lack = 1 in T3.
- 4-beat write burst from adr 0x20, sel 0x3 → words 8..11 written with mask 0x3; 4 acks spaced 2 cycles apart; lack only on the 4th.
- 3-beat read burst starting at word 2^AW−1 → reads words 511, 0, 1 (wrap-around); acks 3 cycles apart; lack on the 3rd.
- bry held low for 5 cycles mid-read-burst → no mem_cs_o during the stall; the burst resumes with correct address and data.
- bl = 0 request → err_o = lack_o = 1 for one cycle, mem_cs_o never asserted. stb dropped mid-write-burst → return to IDLE with no further acks; rst_n pulsed mid-burst → all outputs at reset values.
